// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: arbitrates, issues one command, waits for the result
// (or times out) and holds the response until consumed. Define ALU_ARB_RR_EN for round-robin grant.
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [7:0]  REQ0_A,
  input  logic [7:0]  REQ0_B,
  input  logic [3:0]  REQ0_FUN,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [7:0]  REQ1_A,
  input  logic [7:0]  REQ1_B,
  input  logic [3:0]  REQ1_FUN,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_EN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_OUT_VALID,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_ID,
  output logic        RSP_ERR,
  input  logic        RSP_READY,
  output logic        BUSY
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             grant_c;
  logic             accept_c;
  logic             capture_c;
  logic             timeout_c;
  logic             done_c;

  // Grant selection; only consumed while IDLE, so it cannot move mid-transaction.
`ifdef ALU_ARB_RR_EN
  logic last_q;

  always_comb begin
    grant_c = REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) begin
      grant_c = ~last_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= 1'b1;
    end else if (accept_c) begin
      last_q <= grant_c;
    end
  end
`else
  always_comb begin
    grant_c = ~REQ0_VALID;
  end
`endif

  assign REQ0_READY = (state_q == IDLE) && REQ0_VALID && !grant_c;
  assign REQ1_READY = (state_q == IDLE) && REQ1_VALID && grant_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ0_VALID || REQ1_VALID) begin
          accept_c = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ALU_OUT_VALID) begin
          capture_c = 1'b1;
          state_d   = RESP;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command, wait counter and response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      RSP_VALID  <= 1'b0;
      RSP_DATA   <= '0;
      RSP_ID     <= 1'b0;
      RSP_ERR    <= 1'b0;
      BUSY       <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      ALU_EN <= accept_c;
      BUSY   <= (state_d != IDLE);
      if (accept_c) begin
        ALU_A   <= grant_c ? REQ1_A : REQ0_A;
        ALU_B   <= grant_c ? REQ1_B : REQ0_B;
        ALU_FUN <= grant_c ? REQ1_FUN : REQ0_FUN;
        RSP_ID  <= grant_c;
      end
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      if (capture_c) begin
        RSP_DATA  <= ALU_OUT;
        RSP_ERR   <= 1'b0;
        RSP_VALID <= 1'b1;
      end else if (timeout_c) begin
        RSP_DATA  <= '0;
        RSP_ERR   <= 1'b1;
        RSP_VALID <= 1'b1;
      end else if (done_c) begin
        RSP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU (0:add, 2:mul, 4:and, 15:never valid).
module tb_alu_arbiter;
  localparam int unsigned TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic        REQ0_READY, REQ1_READY;
  logic [7:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]  REQ0_FUN, REQ1_FUN;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        RSP_VALID;
  logic [15:0] RSP_DATA;
  logic        RSP_ID, RSP_ERR;
  logic        RSP_READY;
  logic        BUSY;

  logic        alu_force;
  logic [15:0] alu_force_data;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ID(RSP_ID), .RSP_ERR(RSP_ERR),
    .RSP_READY(RSP_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd4:    return 16'(a & b);
      default: return 16'(a ^ b);
    endcase
  endfunction

  // Result one cycle after ALU_EN; FUN=15 never answers; alu_force injects stray valids.
  always @(posedge CLK) begin
    if (ALU_EN && ALU_FUN != 4'hF) begin
      ALU_OUT_VALID <= 1'b1;
      ALU_OUT       <= alu_model(ALU_A, ALU_B, ALU_FUN);
    end else begin
      ALU_OUT_VALID <= alu_force;
      ALU_OUT       <= alu_force ? alu_force_data : 16'h0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    RSP_READY  = 1'b1;
    while (BUSY && n < 30) begin
      step();
      n++;
    end
    tests_run++;
    if (BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_timeout: BUSY=%b after %0d cycles, want 0", BUSY, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 0;
    REQ0_A = 0; REQ0_B = 0; REQ0_FUN = 0; REQ1_A = 0; REQ1_B = 0; REQ1_FUN = 0;
    alu_force = 0; alu_force_data = 0;
    step();
    tests_run++;
    if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY, REQ0_READY, REQ1_READY} !== 46'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: A=%h B=%h F=%h EN=%b RV=%b RD=%h ID=%b ERR=%b BUSY=%b want all 0",
               ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY);
    end
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_single();
    REQ0_VALID = 1; REQ0_A = 8'd200; REQ0_B = 8'd100; REQ0_FUN = 4'd0; RSP_READY = 1;
    #1;
    tests_run++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready: got %b want 10", {REQ0_READY, REQ1_READY});
    end
    step();
    REQ0_VALID = 0;
    tests_run++;
    if ({ALU_EN, ALU_A, ALU_B, ALU_FUN, BUSY, RSP_VALID} !== {1'b1, 8'd200, 8'd100, 4'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_issue: EN=%b A=%0d B=%0d F=%0d BUSY=%b RV=%b want 1 200 100 0 1 0",
               ALU_EN, ALU_A, ALU_B, ALU_FUN, BUSY, RSP_VALID);
    end
    step();
    tests_run++;
    if ({ALU_EN, RSP_VALID} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_wait: EN=%b RV=%b want 0 0", ALU_EN, RSP_VALID);
    end
    step();
    tests_run++;
    if ({RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, ALU_EN} !== {1'b1, 16'd300, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_rsp: RV=%b D=%0d ID=%b ERR=%b EN=%b want 1 300 0 0 0",
               RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, ALU_EN);
    end
    step();
    tests_run++;
    if ({RSP_VALID, BUSY} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_done: RV=%b BUSY=%b want 0 0", RSP_VALID, BUSY);
    end
  endtask

  task automatic test_wide_result();
    REQ1_VALID = 1; REQ1_A = 8'd255; REQ1_B = 8'd255; REQ1_FUN = 4'd2; RSP_READY = 1;
    step();
    REQ1_VALID = 0;
    step();
    step();
    tests_run++;
    if ({RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR} !== {1'b1, 16'hFE01, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL wide_rsp: RV=%b D=%h ID=%b ERR=%b want 1 fe01 1 0", RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR);
    end
    drain();
  endtask

  task automatic test_contention();
    logic        ids  [3];
    logic [15:0] data [3];
    logic        exp_id [3];
    logic [15:0] exp_d  [3];
    int n;
`ifdef ALU_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0};
    exp_d  = '{16'd255, 16'h0030, 16'd255};
`else
    exp_id = '{1'b0, 1'b0, 1'b0};
    exp_d  = '{16'd255, 16'd255, 16'd255};
`endif
    RST = 1; step(); RST = 0;
    REQ0_VALID = 1; REQ0_A = 8'd15;  REQ0_B = 8'd17;  REQ0_FUN = 4'd2;
    REQ1_VALID = 1; REQ1_A = 8'hF0; REQ1_B = 8'h3C; REQ1_FUN = 4'd4;
    RSP_READY = 1;
    #1;
    tests_run++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      tests_failed++;
      $display("FAIL cont_first_grant: got %b want 10", {REQ0_READY, REQ1_READY});
    end
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      step();
      if (RSP_VALID) begin
        ids[n]  = RSP_ID;
        data[n] = RSP_DATA;
        n++;
      end
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    tests_run++;
    if (n !== 3) begin
      tests_failed++;
      $display("FAIL cont_count: got %0d responses want 3", n);
    end
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if ({ids[i], data[i]} !== {exp_id[i], exp_d[i]}) begin
        tests_failed++;
        $display("FAIL cont_rsp%0d: ID=%b D=%h want ID=%b D=%h", i, ids[i], data[i], exp_id[i], exp_d[i]);
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    REQ1_VALID = 1; REQ1_A = 8'd7; REQ1_B = 8'd9; REQ1_FUN = 4'hF; RSP_READY = 1;
    step();
    REQ1_VALID = 0;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (RSP_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early: RV=%b want 0 before 4 WAIT cycles", RSP_VALID);
    end
    step();
    tests_run++;
    if ({RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR} !== {1'b1, 16'h0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_rsp: RV=%b D=%h ID=%b ERR=%b want 1 0000 1 1", RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic       exp_id;
    logic [7:0] exp_a;
`ifdef ALU_ARB_RR_EN
    exp_id = 1'b1; exp_a = 8'd3;
`else
    exp_id = 1'b0; exp_a = 8'd10;
`endif
    REQ0_VALID = 1; REQ0_A = 8'd10; REQ0_B = 8'd20; REQ0_FUN = 4'd0; RSP_READY = 0;
    REQ1_A = 8'd3; REQ1_B = 8'd4; REQ1_FUN = 4'd0;
    step();
    REQ1_VALID = 1;
    step();
    step();
    alu_force = 1; alu_force_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, REQ0_READY, REQ1_READY, BUSY} !==
          {1'b1, 16'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: RV=%b D=%h ID=%b ERR=%b R0=%b R1=%b BUSY=%b want 1 001e 0 0 0 0 1",
                 i, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, REQ0_READY, REQ1_READY, BUSY);
      end
      step();
    end
    alu_force = 0;
    RSP_READY = 1;
    step();
    tests_run++;
    if ({RSP_VALID, BUSY, ALU_EN, REQ0_READY | REQ1_READY} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_release: RV=%b BUSY=%b EN=%b anyREADY=%b want 0 0 0 1",
               RSP_VALID, BUSY, ALU_EN, REQ0_READY | REQ1_READY);
    end
    step();
    tests_run++;
    if ({ALU_EN, ALU_A, RSP_ID, BUSY} !== {1'b1, exp_a, exp_id, 1'b1}) begin
      tests_failed++;
      $display("FAIL bp_next_accept: EN=%b A=%0d ID=%b BUSY=%b want 1 %0d %b 1", ALU_EN, ALU_A, RSP_ID, BUSY, exp_a, exp_id);
    end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    REQ0_VALID = 1; REQ0_A = 8'd1; REQ0_B = 8'd2; REQ0_FUN = 4'hF; RSP_READY = 1;
    step();
    REQ0_VALID = 0;
    step();
    step();
    RST = 1;
    #1;
    tests_run++;
    if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY} !== 44'h0) begin
      tests_failed++;
      $display("FAIL midrst_async: A=%h B=%h F=%h EN=%b RV=%b D=%h ID=%b ERR=%b BUSY=%b want all 0",
               ALU_A, ALU_B, ALU_FUN, ALU_EN, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY);
    end
    step();
    step();
    REQ0_VALID = 1; REQ0_A = 8'h11; REQ0_B = 8'h01; REQ0_FUN = 4'd0;
    REQ1_VALID = 1; REQ1_A = 8'h22; REQ1_B = 8'h02; REQ1_FUN = 4'd0;
    RST = 0;
    #1;
    tests_run++;
    if ({RSP_VALID, REQ0_READY, REQ1_READY} !== 3'b010) begin
      tests_failed++;
      $display("FAIL midrst_grant: RV=%b R0=%b R1=%b want 0 1 0", RSP_VALID, REQ0_READY, REQ1_READY);
    end
    step();
    tests_run++;
    if ({ALU_EN, ALU_A, RSP_ID} !== {1'b1, 8'h11, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_accept: EN=%b A=%h ID=%b want 1 11 0", ALU_EN, ALU_A, RSP_ID);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wide_result();
    test_contention();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4, the maximum number of WAIT cycles for ALU_OUT_VALID before an error response (legal range 1..15).
REQ-002 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ0_VALID / REQ1_VALID  input  1  requester n has a command pending.
REQ-005 REQ0_READY / REQ1_READY  output  1  command n is accepted on this edge when VALID is also high.
REQ-006 REQ0_A, REQ0_B / REQ1_A, REQ1_B  input  8  operands.
REQ-007 REQ0_FUN / REQ1_FUN  input  4  ALU function code.
REQ-008 ALU_A, ALU_B  output  8, and ALU_FUN  output  4  registered operands and function code driven to the shared ALU.
REQ-009 ALU_EN  output  1  registered ALU enable.
REQ-010 ALU_OUT  input  16, and ALU_OUT_VALID  input  1  ALU result, valid one cycle after ALU_EN.
REQ-011 RSP_VALID  output  1, RSP_DATA  output  16, RSP_ID  output  1, RSP_ERR  output  1  response to the served requester.
REQ-012 RSP_READY  input  1  the consumer accepts the response.
REQ-013 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with a 2-bit state encoding.
REQ-015 REQn_READY SHALL be combinational: high only in IDLE and only for the granted requester; at most one READY is high.
REQ-016 On an accept edge the block SHALL:
- latch A, B and FUN into ALU_A, ALU_B and ALU_FUN;
- record the grant in RSP_ID;
- go to ISSUE.
REQ-017 In ISSUE, ALU_EN SHALL be high for exactly one cycle; the FSM then goes to WAIT and ALU_EN returns low.
REQ-018 In WAIT with ALU_OUT_VALID high, the block SHALL capture ALU_OUT into RSP_DATA, clear RSP_ERR and go to RESP.
- Nominal latency: RSP_VALID is high 2 cycles after the accept edge.
REQ-019 A 4-bit WAIT counter SHALL clear on entry to WAIT.
- If TIMEOUT cycles elapse without ALU_OUT_VALID, the block SHALL set RSP_DATA=0 and RSP_ERR=1 and go to RESP.
- This covers FUN=4'b1111, for which the ALU never asserts valid.
REQ-020 In RESP, RSP_VALID, RSP_DATA, RSP_ID and RSP_ERR SHALL hold stable until RSP_READY is high; on that edge RSP_VALID clears and the FSM returns to IDLE.
REQ-021 A new command SHALL NOT be accepted on the same edge as response completion; the earliest next accept is one cycle later.
REQ-022 ALU_OUT_VALID SHALL be ignored outside WAIT.
REQ-023 ALU_OUT SHALL pass to RSP_DATA unmodified (16 bits, no sign extension or truncation).
REQ-024 The grant SHALL change only in IDLE; a requester that drops VALID before acceptance loses nothing.

Reset
REQ-025 While RST is high, the block SHALL force the following, regardless of CLK:
- state=IDLE;
- ALU_A=ALU_B=0, ALU_FUN=0, ALU_EN=0;
- RSP_VALID=0, RSP_DATA=0, RSP_ID=0, RSP_ERR=0;
- BUSY=0, WAIT counter=0, last-served pointer=1.
REQ-026 Reset during ISSUE, WAIT or RESP SHALL abort the operation with no response; no pending response survives reset.

Configuration
REQ-027 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin:
- when both requesters are valid, the requester not last served wins;
- the pointer updates on each accept;
- after reset, REQ0 wins first.
REQ-028 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority: REQ0 always wins when valid, and no pointer is implemented.

Verification
REQ-029 Single command: REQ0 with A=8'd200, B=8'd100, FUN=0 and RSP_READY=1 -> ALU_EN pulses once; RSP_VALID rises 2 cycles after accept with RSP_DATA=16'd300, RSP_ID=0, RSP_ERR=0.
REQ-030 Contention with RR: both requesters valid continuously, REQ0 FUN=2 (A=8'd15, B=8'd17), REQ1 FUN=4 (A=8'hF0, B=8'h3C) -> responses alternate:
- ID 0: RSP_DATA=16'd255;
- ID 1: RSP_DATA=16'h0030;
- ID 0 again.
- Without the macro: every response has ID 0.
REQ-031 Timeout: REQ1 with FUN=4'b1111 and TIMEOUT=4 -> RSP_VALID rises after 4 WAIT cycles with RSP_ERR=1, RSP_DATA=0, RSP_ID=1.
REQ-032 Backpressure: RSP_READY held low for 5 cycles -> response fields stable and both READYs low; RSP_READY high -> IDLE next cycle, next accept one cycle later.
REQ-033 Reset mid-WAIT: assert RST in WAIT -> all outputs 0 immediately, no RSP_VALID; after release, REQ0 is granted first when both are valid.
